// File: rtl/wb_shared_bus.sv
// Wishbone shared bus: NUM_M masters arbitrated round-robin onto NUM_S base/mask-decoded
// slaves, with error responses for unmapped addresses and a strobe watchdog.
module wb_shared_bus #(
  parameter int unsigned           NUM_M   = 2,
  parameter int unsigned           NUM_S   = 4,
  parameter logic [NUM_S*32-1:0]   S_BASE  = {NUM_S{32'h0000_0000}},
  parameter logic [NUM_S*32-1:0]   S_MASK  = {NUM_S{32'hF000_0000}},
  parameter int unsigned           TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_M*32-1:0]   m_adr_i,
  input  logic [NUM_M*32-1:0]   m_dat_i,
  input  logic [NUM_M*4-1:0]    m_sel_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  output logic [31:0]           m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [NUM_M-1:0]      m_rty_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic [NUM_S-1:0]      s_cyc_o,
  output logic [NUM_S-1:0]      s_stb_o,
  input  logic [NUM_S*32-1:0]   s_dat_i,
  input  logic [NUM_S-1:0]      s_ack_i,
  input  logic [NUM_S-1:0]      s_err_i,
  input  logic [NUM_S-1:0]      s_rty_i,
  output logic [NUM_M-1:0]      gnt_o
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic [NUM_M-1:0] gnt_q;
  logic [MW-1:0]    last_q;
  logic [TW-1:0]    wd_q, wd_d;
  logic             uerr_q, uerr_d;

  logic [MW-1:0]    arb_idx;
  logic             arb_any;
  int               arb_c;
  logic [31:0]      g_adr, g_dat;
  logic [3:0]       g_sel;
  logic             g_we, g_cyc, g_stb;
  logic [NUM_S-1:0] hit;
  logic             any_hit;
  logic [31:0]      r_dat;
  logic             r_ack, r_err, r_rty;
  logic             resp, tmo;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    arb_idx = '0;
    arb_any = 1'b0;
    arb_c   = 0;
    for (int k = 1; k <= int'(NUM_M); k++) begin
      arb_c = (int'(last_q) + k) % int'(NUM_M);
      if (!arb_any && m_cyc_i[arb_c]) begin
        arb_any = 1'b1;
        arb_idx = MW'(arb_c);
      end
    end
  end

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (gnt_q[i]) begin
        g_adr = m_adr_i[i*32 +: 32];
        g_dat = m_dat_i[i*32 +: 32];
        g_sel = m_sel_i[i*4 +: 4];
        g_we  = m_we_i[i];
      end
    end
    g_cyc = |(gnt_q & m_cyc_i);
    g_stb = |(gnt_q & m_stb_i);
  end

  // Lowest-index slave wins when windows overlap; nothing decodes without a grant.
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    for (int j = 0; j < int'(NUM_S); j++) begin
      if (!any_hit && (|gnt_q) &&
          ((g_adr & S_MASK[j*32 +: 32]) == (S_BASE[j*32 +: 32] & S_MASK[j*32 +: 32]))) begin
        hit[j]  = 1'b1;
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    r_dat = '0;
    r_ack = 1'b0;
    r_err = 1'b0;
    r_rty = 1'b0;
    for (int j = 0; j < int'(NUM_S); j++) begin
      if (hit[j]) begin
        r_dat = s_dat_i[j*32 +: 32];
        r_ack = s_ack_i[j];
        r_err = s_err_i[j];
        r_rty = s_rty_i[j];
      end
    end
  end

  // Any response in the expiry cycle beats the watchdog.
  assign resp   = r_ack | r_err | r_rty | uerr_q;
  assign tmo    = (TIMEOUT != 0) && g_cyc && g_stb && !resp && (wd_q == TW'(TIMEOUT - 1));
  assign uerr_d = g_cyc & g_stb & ~any_hit & ~uerr_q;

  always_comb begin
    wd_d = '0;
    if ((TIMEOUT != 0) && g_cyc && g_stb && !resp && !tmo) wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= MW'(NUM_M - 1);
      wd_q    <= '0;
      uerr_q  <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      uerr_q <= uerr_d;
      case (state_q)
        IDLE: if (arb_any) begin
          gnt_q   <= NUM_M'(1) << arb_idx;
          last_q  <= arb_idx;
          state_q <= BUSY;
        end
        BUSY: if (!g_cyc) begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = {NUM_S{g_cyc}} & hit;
  assign s_stb_o = {NUM_S{g_stb}} & hit;
  assign m_dat_o = r_dat;
  assign m_ack_o = gnt_q & {NUM_M{r_ack}};
  assign m_err_o = gnt_q & {NUM_M{r_err | uerr_q | tmo}};
  assign m_rty_o = gnt_q & {NUM_M{r_rty}};

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: directed scenarios plus random traffic, every cycle compared
// against a transaction-level reference model of arbitration, decode and error rules.
module tb_wb_shared_bus;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASE = {32'h8000_0000, 32'h0000_0100, 32'h0000_0000, 32'h4000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hC000_0000, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst;
  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*32-1:0] s_dat;
  logic [NS-1:0]    s_ack, s_err, s_rty;

  wb_shared_bus #(.NUM_M(NM), .NUM_S(NS), .S_BASE(BASE), .S_MASK(MASK), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: owner of the bus (-1 = none), last owner, length of the
  // current no-response strobe run, length of the current unmapped strobe run.
  int own = -1;
  int last = NM - 1;
  int wd = 0;
  int urun = 0;
  bit upl = 1'b0;
  logic [NM-1:0] rsp_vec = '0;
  int wait_c [NM];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int j = 0; j < NS; j++)
      if ((a & MASK[j*32 +: 32]) == (BASE[j*32 +: 32] & MASK[j*32 +: 32])) return j;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1; last = NM - 1; wd = 0; urun = 0; upl = 1'b0; rsp_vec = '0;
  endtask

  // Check every output mid-cycle against the model, then advance the model over the edge.
  task automatic step();
    logic [NM-1:0] eg, ea, ee, er;
    logic [NS-1:0] ec, es;
    logic [31:0]   ed, eadr, edat;
    logic [3:0]    esel;
    logic          ewe;
    int j, cnt, nown;
    bit act, sack, serr, srty, resp, tmo, unm;
    @(negedge clk);
    eg = '0; ea = '0; ee = '0; er = '0; ec = '0; es = '0;
    ed = '0; eadr = '0; edat = '0; esel = '0; ewe = 1'b0;
    j = -1; cnt = 0; act = 0; sack = 0; serr = 0; srty = 0; resp = 0; tmo = 0; unm = 0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      eadr = m_adr[own*32 +: 32];
      edat = m_dat[own*32 +: 32];
      esel = m_sel[own*4 +: 4];
      ewe  = m_we[own];
      j    = dec(eadr);
      act  = m_cyc[own] && m_stb[own];
      if (j >= 0) begin
        ec[j] = m_cyc[own]; es[j] = m_stb[own];
        ed = s_dat[j*32 +: 32];
        sack = s_ack[j]; serr = s_err[j]; srty = s_rty[j];
      end
      unm  = act && (j < 0);
      resp = sack || serr || srty || upl;
      cnt  = (act && !resp) ? wd + 1 : 0;
      tmo  = (cnt == TO);
      ea[own] = sack;
      ee[own] = serr || upl || tmo;
      er[own] = srty;
    end
    chk("gnt", gnt_o, eg);
    chk("s_cyc", s_cyc_o, ec);
    chk("s_stb", s_stb_o, es);
    chk("s_adr", s_adr_o, eadr);
    chk("s_dat", s_dat_o, edat);
    chk("s_sel", s_sel_o, esel);
    chk("s_we", s_we_o, ewe);
    chk("m_dat", m_dat_o, ed);
    chk("m_ack", m_ack_o, ea);
    chk("m_err", m_err_o, ee);
    chk("m_rty", m_rty_o, er);
    rsp_vec = ea | ee | er;
    nown = own;
    if (own < 0) begin
      for (int k = 1; k <= NM; k++)
        if (nown < 0 && m_cyc[(last + k) % NM]) nown = (last + k) % NM;
    end else if (!m_cyc[own]) nown = -1;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (own < 0 && nown >= 0) last = nown;
      upl  = unm && ((urun + 1) % 2 == 1);
      urun = unm ? urun + 1 : 0;
      wd   = tmo ? 0 : cnt;
      own  = nown;
    end
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] a, input logic we, input logic cyc, input logic stb);
    m_adr[i*32 +: 32] = a;
    m_dat[i*32 +: 32] = $urandom;
    m_sel[i*4 +: 4]   = 4'hF;
    m_we[i]  = we;
    m_cyc[i] = cyc;
    m_stb[i] = stb;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 6))
      0:       return 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      1:       return 32'h0000_0100 | ($urandom & 32'h0000_00FC);
      2:       return $urandom & 32'h0000_0FFC;
      3:       return 32'h8000_0000 | ($urandom & 32'h3FFF_FFFC);
      4:       return 32'hDEAD_0000;
      5:       return 32'hC000_0000 | ($urandom & 32'h0FFF_FFFC);
      default: return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
    endcase
  endfunction

  task automatic new_req(input int i);
    m_adr[i*32 +: 32] = raddr();
    m_dat[i*32 +: 32] = $urandom;
    m_sel[i*4 +: 4]   = 4'($urandom_range(0, 15));
    m_we[i]  = 1'($urandom_range(0, 1));
    m_stb[i] = 1'b1;
  endtask

  task automatic rand_cycle();
    int r;
    for (int i = 0; i < NM; i++) begin
      if (m_cyc[i]) begin
        if (rsp_vec[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; wait_c[i] = $urandom_range(0, 3);
          end else new_req(i);
        end else if ($urandom_range(0, 31) == 0) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) m_stb[i] = ~m_stb[i];
      end else if (wait_c[i] > 0) wait_c[i]--;
      else if ($urandom_range(0, 2) == 0) begin
        m_cyc[i] = 1'b1; new_req(i);
      end
    end
    for (int j = 0; j < NS; j++) begin
      r = $urandom_range(0, 15);
      s_ack[j] = (r == 0) || (r == 3);
      s_err[j] = (r == 1) || (r == 3);
      s_rty[j] = (r == 2);
      s_dat[j*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    s_dat = '0; s_ack = '0; s_err = '0; s_rty = '0;
    for (int i = 0; i < NM; i++) wait_c[i] = 0;
    model_reset();
    // Requests during reset must not be granted
    set_m(0, 32'h4000_0000, 0, 1, 1);
    set_m(1, 32'h0000_0010, 0, 1, 1);
    step(); step();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    idle_all();
    rst = 1'b0;
    step();

    // Single read, slave 0 acks on the third strobe cycle
    set_m(0, 32'h4000_0010, 0, 1, 1);
    s_dat[31:0] = 32'hCAFE_BABE;
    step(); #1;
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_stb", s_stb_o, 4'b0001);
    step(); step();
    s_ack[0] = 1'b1; #1;
    chk("t1_ack", m_ack_o, 2'b01);
    chk("t1_dat", m_dat_o, 32'hCAFE_BABE);
    step();
    s_ack = '0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step(); step();

    // Round-robin contention from reset
    do_reset();
    set_m(0, 32'h0000_0020, 0, 1, 1);
    set_m(1, 32'h8000_0040, 1, 1, 1);
    step(); #1;
    chk("rr_first", gnt_o, 2'b01);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step(); #1;
    chk("rr_idle", gnt_o, 2'b00);
    step(); #1;
    chk("rr_second", gnt_o, 2'b10);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    m_cyc = 2'b11; m_stb = 2'b11;
    step(); #1;
    chk("rr_third", gnt_o, 2'b01);
    idle_all(); step(); step();

    // Unmapped write: single error pulse one cycle after the strobe
    set_m(0, 32'hDEAD_0000, 1, 1, 1);
    step(); #1;
    chk("unm_stb", s_stb_o, 4'b0000);
    chk("unm_err0", m_err_o, 2'b00);
    step(); #1;
    chk("unm_pulse", m_err_o, 2'b01);
    m_stb[0] = 1'b0;
    step(); #1;
    chk("unm_once", m_err_o, 2'b00);
    step(); #1;
    chk("unm_once2", m_err_o, 2'b00);
    // Held strobe: pulses every other cycle
    m_stb[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("unm_hold", m_err_o, (k % 2 == 1) ? 2'b01 : 2'b00);
      step();
    end
    idle_all(); step(); step();

    // Watchdog: error on the 8th unanswered strobe cycle
    set_m(0, 32'h4000_0100, 0, 1, 1);
    step();
    for (int k = 1; k <= 8; k++) begin
      #1 chk("wd_err", m_err_o[0], k == 8);
      step();
    end
    m_stb[0] = 1'b0;
    step();
    m_stb[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) s_ack[0] = 1'b1;
      #1 chk("wd_ack_noerr", m_err_o[0], 1'b0);
      if (k == 8) chk("wd_ack", m_ack_o[0], 1'b1);
      step();
    end
    idle_all(); step(); step();

    // Overlapping windows: lower index slave wins
    set_m(0, 32'h0000_0100, 0, 1, 1);
    step(); #1;
    chk("ovl_stb", s_stb_o, 4'b0010);
    chk("ovl_cyc", s_cyc_o, 4'b0010);
    idle_all(); step(); step();

    // Asynchronous reset in the middle of an acked burst
    set_m(0, 32'h4000_0004, 0, 1, 1);
    s_ack[0] = 1'b1;
    step(); step(); #1;
    chk("mid_ack", m_ack_o, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("arst_cyc", s_cyc_o, 0);
    chk("arst_gnt", gnt_o, 0);
    chk("arst_ack", m_ack_o, 0);
    model_reset();
    set_m(1, 32'h0000_0008, 0, 1, 1);
    step(); step();
    rst = 1'b0;
    step(); #1;
    chk("arst_regrant", gnt_o, 2'b01);
    step();
    idle_all(); step(); step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
